boot_loader_ctrl: RTL

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

---
 rtl/boot_loader_ctrl_if.sv | 27 ++
 rtl/boot_loader_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl_if.sv
// rtl/boot_loader_ctrl_if.sv - SPI flash pins and boot RAM write port of the boot loader
//   spi_sdi      flash serial data into the controller
//   spi_sdo      flash serial data out of the controller
//   spi_sclk     SPI clock, mode 0
//   spi_cs       flash chip select, active low
//   ram_wr_en    one-cycle boot RAM write strobe
//   ram_wr_addr  boot RAM byte address
//   ram_wr_data  boot RAM write data
interface boot_loader_ctrl_if;
    logic        spi_sdi;
    logic        spi_sdo;
    logic        spi_sclk;
    logic        spi_cs;
    logic        ram_wr_en;
    logic [31:0] ram_wr_addr;
    logic [31:0] ram_wr_data;

    modport master (
        input  spi_sdi,
        output spi_sdo, spi_sclk, spi_cs, ram_wr_en, ram_wr_addr, ram_wr_data
    );

    modport slave (
        output spi_sdi,
        input  spi_sdo, spi_sclk, spi_cs, ram_wr_en, ram_wr_addr, ram_wr_data
    );
endinterface

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - copies BOOT_WORDS words from SPI flash into boot RAM, then releases core reset
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   bus        SPI flash pins and boot RAM write port (master side)
//   sys_rst_n  core reset, active low, released once the copy completes
//   boot_busy  high while the copy is in progress
//   boot_done  high after the copy completes, sticky until rst
module boot_loader_ctrl #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned BOOT_WORDS = 1024,
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter logic [31:0] RAM_BASE   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    boot_loader_ctrl_if.master bus,
    output logic               sys_rst_n,
    output logic               boot_busy,
    output logic               boot_done
);
    typedef enum logic [2:0] {
        IDLE, CS_SETUP, CMD, ADDR, DATA, WRITE, CS_HOLD, DONE
    } state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [31:0] WORDS     = 32'(BOOT_WORDS);
    localparam logic [7:0]  READ_CMD  = 8'h03;

    state_t      state, state_nx;
    logic [7:0]  div_cnt, div_nx;
    logic [4:0]  bit_cnt, bit_nx;
    logic [31:0] tx_shift, tx_nx;
    logic [31:0] rx_shift, rx_nx;
    logic [22:0] word_index, idx_nx;
    logic        sclk_q, sclk_nx;
    logic        sdo_q, sdo_nx;
    logic        cs_q, cs_nx;
    logic        wr_en_q, wr_en_nx;
    logic [31:0] wr_addr_q, wr_addr_nx;
    logic [31:0] wr_data_q, wr_data_nx;
    logic        srn_q, srn_nx;
    logic        busy_q, busy_nx;
    logic        done_q, done_nx;
    logic        phase_end;

    assign phase_end = (div_cnt == DIV_LAST);

    always_comb begin
        state_nx   = state;
        div_nx     = div_cnt;
        bit_nx     = bit_cnt;
        tx_nx      = tx_shift;
        rx_nx      = rx_shift;
        idx_nx     = word_index;
        sclk_nx    = sclk_q;
        sdo_nx     = sdo_q;
        cs_nx      = cs_q;
        wr_en_nx   = 1'b0;
        wr_addr_nx = wr_addr_q;
        wr_data_nx = wr_data_q;
        srn_nx     = srn_q;
        busy_nx    = busy_q;
        done_nx    = done_q;

        case (state)
            IDLE: begin
                state_nx = CS_SETUP;
                cs_nx    = 1'b0;
                busy_nx  = 1'b1;
                div_nx   = 8'd0;
                bit_nx   = 5'd0;
                idx_nx   = 23'd0;
                // command and address go out as one 32-bit MSB-first stream
                tx_nx    = {READ_CMD, FLASH_BASE};
            end

            CS_SETUP: begin
                if (phase_end) begin
                    state_nx = CMD;
                    div_nx   = 8'd0;
                    sdo_nx   = tx_shift[31];
                    tx_nx    = {tx_shift[30:0], 1'b0};
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end

            CMD, ADDR, DATA: begin
                if (!phase_end) begin
                    div_nx = div_cnt + 8'd1;
                end else begin
                    div_nx = 8'd0;
                    if (!sclk_q) begin
                        // end of low phase: raise sclk and sample on the same edge
                        sclk_nx = 1'b1;
                        if (state == DATA) begin
                            rx_nx = {rx_shift[30:0], bus.spi_sdi};
                        end
                    end else begin
                        // end of high phase: bit is complete
                        sclk_nx = 1'b0;
                        bit_nx  = bit_cnt + 5'd1;
                        if (state == DATA) begin
                            if (bit_cnt == 5'd31) begin
                                state_nx   = WRITE;
                                wr_en_nx   = 1'b1;
                                // first byte received lands in the low byte
                                wr_data_nx = {rx_shift[7:0], rx_shift[15:8],
                                              rx_shift[23:16], rx_shift[31:24]};
                                wr_addr_nx = RAM_BASE + {7'd0, word_index, 2'b00};
                            end
                        end else if (bit_cnt == 5'd31) begin
                            state_nx = DATA;
                            sdo_nx   = 1'b0;
                        end else begin
                            if (bit_cnt == 5'd7) begin
                                state_nx = ADDR;
                            end
                            sdo_nx = tx_shift[31];
                            tx_nx  = {tx_shift[30:0], 1'b0};
                        end
                    end
                end
            end

            WRITE: begin
                idx_nx = word_index + 23'd1;
                div_nx = 8'd0;
                if (({9'd0, word_index} + 32'd1) < WORDS) begin
                    state_nx = DATA;
                end else begin
                    state_nx = CS_HOLD;
                end
            end

            CS_HOLD: begin
                if (phase_end) begin
                    state_nx = DONE;
                    cs_nx    = 1'b1;
                    srn_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    div_nx = div_cnt + 8'd1;
                end
            end

            DONE: begin
                state_nx = DONE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= 8'd0;
            bit_cnt    <= 5'd0;
            tx_shift   <= 32'd0;
            rx_shift   <= 32'd0;
            word_index <= 23'd0;
            sclk_q     <= 1'b0;
            sdo_q      <= 1'b0;
            cs_q       <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 32'd0;
            srn_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            div_cnt    <= div_nx;
            bit_cnt    <= bit_nx;
            tx_shift   <= tx_nx;
            rx_shift   <= rx_nx;
            word_index <= idx_nx;
            sclk_q     <= sclk_nx;
            sdo_q      <= sdo_nx;
            cs_q       <= cs_nx;
            wr_en_q    <= wr_en_nx;
            wr_addr_q  <= wr_addr_nx;
            wr_data_q  <= wr_data_nx;
            srn_q      <= srn_nx;
            busy_q     <= busy_nx;
            done_q     <= done_nx;
        end
    end

    assign bus.spi_sclk    = sclk_q;
    assign bus.spi_sdo     = sdo_q;
    assign bus.spi_cs      = cs_q;
    assign bus.ram_wr_en   = wr_en_q;
    assign bus.ram_wr_addr = wr_addr_q;
    assign bus.ram_wr_data = wr_data_q;
    assign sys_rst_n       = srn_q;
    assign boot_busy       = busy_q;
    assign boot_done       = done_q;
endmodule
